// File: rtl/seg_mux_ctrl_pkg.sv
// seg_pkg: shared types and constants for the two-digit seven-segment multiplexer
package seg_pkg;
    typedef enum logic [1:0] {BLANK_L, SHOW_L, BLANK_R, SHOW_R} mux_state_t;
    typedef logic [3:0] hex_t;
    localparam logic [1:0] AN_OFF = 2'b11;
endpackage

// File: rtl/seg_mux_ctrl_if.sv
// seg_mux_ctrl_if: digit load bus in, decoder nibble and anode enables out
interface seg_mux_ctrl_if;
    import seg_pkg::*;
    logic digit_valid;
    hex_t digit_in;
    logic clear;
    logic blank_all;
    hex_t s;
    logic [1:0] an_n;
    hex_t digit_l;
    hex_t digit_r;
    modport master (
        output digit_valid, digit_in, clear, blank_all,
        input s, an_n, digit_l, digit_r
    );
    modport slave (
        input digit_valid, digit_in, clear, blank_all,
        output s, an_n, digit_l, digit_r
    );
endinterface

// File: rtl/seg_phase_timer.sv
// seg_phase_timer: down-counter that pulses tc on the last cycle of a phase
module seg_phase_timer #(
    parameter int ON_CYCLES    = 10000,
    parameter int BLANK_CYCLES = 100,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_on,
    output logic tc
);
    logic [CNT_W-1:0] cnt;
    assign tc = cnt == '0;
    // reload with the length of the upcoming phase at terminal count
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= CNT_W'(BLANK_CYCLES - 1);
        else cnt <= tc ? (load_on ? CNT_W'(ON_CYCLES - 1) : CNT_W'(BLANK_CYCLES - 1)) : cnt - CNT_W'(1);
endmodule

// File: rtl/seg_mux_ctrl.sv
// seg_mux_ctrl: time-multiplexes one hex decoder across two common-anode digits with dead-time blanking
module seg_mux_ctrl
    import seg_pkg::*;
#(
    parameter int ON_CYCLES    = 10000,
    parameter int BLANK_CYCLES = 100,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    seg_mux_ctrl_if.slave bus
);
    if (ON_CYCLES < 1 || BLANK_CYCLES < 1 || (ON_CYCLES >> CNT_W) != 0 || (BLANK_CYCLES >> CNT_W) != 0) begin : g_param_err
        $error("seg_mux_ctrl: ON_CYCLES/BLANK_CYCLES must be >= 1 and fit in CNT_W bits");
    end
    mux_state_t state;
    hex_t digit_l, digit_r;
    logic blank_q, tc, show;
    assign show = state inside {SHOW_L, SHOW_R};
    seg_phase_timer #(
        .ON_CYCLES(ON_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES),
        .CNT_W(CNT_W)
    ) u_timer (
        .clk(clk),
        .reset(reset),
        .load_on(!show),
        .tc(tc)
    );
    // advance BLANK_L -> SHOW_L -> BLANK_R -> SHOW_R -> BLANK_L on terminal count
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= BLANK_L;
        else if (tc) state <= mux_state_t'(state + 2'd1);
    // two-digit shift register; clear drops a simultaneous load
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            digit_l <= '0;
            digit_r <= '0;
        end else if (bus.clear) begin
            digit_l <= '0;
            digit_r <= '0;
        end else if (bus.digit_valid) begin
            digit_l <= digit_r;
            digit_r <= bus.digit_in;
        end
    // registered blank request keeps inputs off the anode path
    always_ff @(posedge clk or posedge reset)
        if (reset) blank_q <= 1'b0;
        else blank_q <= bus.blank_all;
    assign bus.s       = state inside {BLANK_L, SHOW_L} ? digit_l : digit_r;
    assign bus.an_n    = (blank_q || !show) ? AN_OFF : (state == SHOW_L ? 2'b01 : 2'b10);
    assign bus.digit_l = digit_l;
    assign bus.digit_r = digit_r;
endmodule

// File: tb/tb_seg_mux_ctrl.sv
// tb_seg_mux_ctrl: directed and random checks of seg_mux_ctrl against a phase-position model
module tb_seg_mux_ctrl;
    localparam int ON = 4;
    localparam int BL = 2;
    localparam int PER = 2 * (ON + BL);
    localparam logic [1:0] AN_TAB [12] = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01,
                                           2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
    localparam logic [1:0] BL_TAB [12] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11,
                                           2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10};
    logic clk = 0;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    int t, p;
    logic [3:0] md_l, md_r, exp_s;
    logic [1:0] exp_an;
    logic mbq;
    seg_mux_ctrl_if bus();
    seg_mux_ctrl #(.ON_CYCLES(ON), .BLANK_CYCLES(BL), .CNT_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    // model: position within the period since reset release decides the anodes
    always @(posedge clk) begin
        if (reset) begin
            t = 0;
            md_l = 0;
            md_r = 0;
            mbq = 0;
        end else begin
            t++;
            if (bus.clear) begin
                md_l = 0;
                md_r = 0;
            end else if (bus.digit_valid) begin
                md_l = md_r;
                md_r = bus.digit_in;
            end
            mbq = bus.blank_all;
        end
        #1;
        p = t % PER;
        exp_an = mbq || p < BL || (p >= BL + ON && p < 2 * BL + ON) ? 2'b11 : p < BL + ON ? 2'b01 : 2'b10;
        exp_s = p < BL + ON ? md_l : md_r;
        chk("model_an_n", bus.an_n, exp_an);
        chk("model_s", bus.s, exp_s);
        chk("model_digit_l", bus.digit_l, md_l);
        chk("model_digit_r", bus.digit_r, md_r);
    end

    initial begin
        logic [1:0] prev_lit;
        int run;
        reset = 1;
        bus.digit_valid = 0;
        bus.digit_in = 0;
        bus.clear = 0;
        bus.blank_all = 0;
        repeat (2) @(negedge clk);
        chk("rst_an_n", bus.an_n, 2'b11);
        chk("rst_s", bus.s, 0);
        chk("rst_digit_l", bus.digit_l, 0);
        chk("rst_digit_r", bus.digit_r, 0);
        reset = 0;
        for (int k = 0; k < 2 * PER; k++) begin
            if (k > 0) @(negedge clk);
            chk("seq_an_n", bus.an_n, AN_TAB[k % 12]);
            chk("seq_s", bus.s, 0);
        end
        bus.digit_valid = 1;
        bus.digit_in = 4'h3;
        @(negedge clk);
        bus.digit_in = 4'h7;
        @(negedge clk);
        bus.digit_valid = 0;
        chk("load_digit_l", bus.digit_l, 4'h3);
        chk("load_digit_r", bus.digit_r, 4'h7);
        repeat (11) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk("load_an_n", bus.an_n, AN_TAB[k]);
            chk("load_s", bus.s, k < 6 ? 4'h3 : 4'h7);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("blank_an_n", bus.an_n, BL_TAB[k]);
            chk("blank_s", bus.s, k < 6 ? 4'h3 : 4'h7);
            if (k == 2) bus.blank_all = 1;
            if (k == 9) bus.blank_all = 0;
        end
        @(negedge clk);
        bus.clear = 1;
        bus.digit_valid = 1;
        bus.digit_in = 4'hA;
        @(negedge clk);
        bus.clear = 0;
        chk("clr_digit_l", bus.digit_l, 0);
        chk("clr_digit_r", bus.digit_r, 0);
        bus.digit_in = 4'h3;
        @(negedge clk);
        bus.digit_in = 4'h7;
        @(negedge clk);
        bus.digit_valid = 0;
        repeat (6) @(negedge clk);
        chk("pre_rst_an_n", bus.an_n, 2'b10);
        chk("pre_rst_s", bus.s, 4'h7);
        reset = 1;
        #1;
        chk("async_rst_an_n", bus.an_n, 2'b11);
        chk("async_rst_s", bus.s, 0);
        chk("async_rst_digit_r", bus.digit_r, 0);
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk("restart_an_n", bus.an_n, AN_TAB[k]);
            chk("restart_s", bus.s, 0);
        end
        prev_lit = 2'b11;
        run = 2;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            chk("an_n_not_00", bus.an_n != 2'b00, 1);
            if (bus.an_n == 2'b11) run++;
            else begin
                if (prev_lit != 2'b11 && prev_lit != bus.an_n) chk("dead_time_gap", run >= 2, 1);
                prev_lit = bus.an_n;
                run = 0;
            end
            bus.digit_valid = 1'($urandom_range(0, 1));
            bus.digit_in = 4'($urandom_range(0, 15));
            bus.clear = $urandom_range(0, 7) == 0;
            bus.blank_all = $urandom_range(0, 3) == 0;
        end
        bus.digit_valid = 0;
        bus.clear = 0;
        bus.blank_all = 0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
